// File: rtl/line_matrix_v2.sv
// line_matrix_v2 -- registered crossbar from asynchronous RFIC GPO lines to
// accessory output lines.
//
// Each input line is synchronised through SYNC_STAGES flops. Each output picks
// one synchronised source and applies a mode: PASS, INVERT, STRETCH (pulse
// stretch with retrigger) or CONST (level taken from sel[0]). Configuration is
// written into a shadow table and copied into the active table on cfg_commit.
//
// Ports:
//   clk, rst        block clock, synchronous active-high reset
//   input_lines     asynchronous source lines (NUM_IN)
//   output_lines    registered routed outputs (NUM_OUT)
//   cfg_wr          shadow write strobe for entry cfg_addr (cfg_sel, cfg_mode)
//   cfg_commit      copy the whole shadow table into the active table
//   cfg_pending     shadow holds writes that are not yet committed
//   cfg_err         one-cycle pulse on a write to a nonexistent output
//   rd_addr         readback index into the active table
//   rd_sel, rd_mode registered readback of active[rd_addr]
module line_matrix_v2 #(
    parameter int NUM_IN         = 8,
    parameter int NUM_OUT        = 10,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 16,
    parameter int SEL_W          = $clog2(NUM_IN),
    parameter int ADDR_W         = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IN-1:0]  input_lines,
    output logic [NUM_OUT-1:0] output_lines,
    input  logic               cfg_wr,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [SEL_W-1:0]   cfg_sel,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_commit,
    output logic               cfg_pending,
    output logic               cfg_err,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [SEL_W-1:0]   rd_sel,
    output logic [1:0]         rd_mode
);

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_INVERT  = 2'd1;
    localparam logic [1:0] MODE_STRETCH = 2'd2;
    localparam logic [1:0] MODE_CONST   = 2'd3;

    localparam int               CNT_W        = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    // One extra bit so NUM_OUT / NUM_IN themselves are representable.
    localparam logic [ADDR_W:0]  NUM_OUT_L    = (ADDR_W + 1)'(NUM_OUT);
    localparam logic [SEL_W:0]   NUM_IN_L     = (SEL_W + 1)'(NUM_IN);

    logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_q, sync_d;
    logic [NUM_IN-1:0]                  s;

    logic [NUM_OUT-1:0][SEL_W-1:0] shadow_sel_q, shadow_sel_d;
    logic [NUM_OUT-1:0][1:0]       shadow_mode_q, shadow_mode_d;
    logic [NUM_OUT-1:0][SEL_W-1:0] active_sel_q, active_sel_d;
    logic [NUM_OUT-1:0][1:0]       active_mode_q, active_mode_d;
    logic [NUM_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_OUT-1:0]            prev_q, prev_d;
    logic [NUM_OUT-1:0]            out_q, out_d;

    logic             pending_q, pending_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] rd_sel_q, rd_sel_d;
    logic [1:0]       rd_mode_q, rd_mode_d;

    logic wr_ok;
    logic rd_ok;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], input_lines};
    end

    // Configuration: shadow write, commit, pending flag, error pulse, readback.
    always_comb begin
        wr_ok         = cfg_wr && ({1'b0, cfg_addr} < NUM_OUT_L);
        rd_ok         = ({1'b0, rd_addr} < NUM_OUT_L);
        shadow_sel_d  = shadow_sel_q;
        shadow_mode_d = shadow_mode_q;
        if (wr_ok) begin
            shadow_sel_d[cfg_addr]  = cfg_sel;
            shadow_mode_d[cfg_addr] = cfg_mode;
        end
        // Commit copies the registered shadow, so a write in the same cycle
        // stays pending for the next commit.
        active_sel_d  = cfg_commit ? shadow_sel_q  : active_sel_q;
        active_mode_d = cfg_commit ? shadow_mode_q : active_mode_q;
        if (wr_ok) begin
            pending_d = 1'b1;
        end else if (cfg_commit) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        err_d     = cfg_wr && !wr_ok;
        rd_sel_d  = rd_ok ? active_sel_q[rd_addr]  : '0;
        rd_mode_d = rd_ok ? active_mode_q[rd_addr] : MODE_CONST;
    end

    // Per-output routing and stretch logic.
    always_comb begin
        logic src_ok;
        logic src;
        src_ok = 1'b0;
        src    = 1'b0;
        cnt_d  = '0;
        prev_d = '0;
        out_d  = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            src_ok    = ({1'b0, active_sel_q[k]} < NUM_IN_L);
            src       = src_ok & s[active_sel_q[k]];
            prev_d[k] = src;
            if (active_mode_q[k] == MODE_STRETCH) begin
                // Counter is reloaded on a rising edge and held while the
                // source stays high, so the stretch tail starts at the fall.
                if (src && !prev_q[k]) begin
                    cnt_d[k] = STRETCH_LOAD;
                end else if (src) begin
                    cnt_d[k] = cnt_q[k];
                end else if (cnt_q[k] != '0) begin
                    cnt_d[k] = cnt_q[k] - CNT_ONE;
                end
            end
            case (active_mode_q[k])
                MODE_PASS:    out_d[k] = src;
                MODE_INVERT:  out_d[k] = src_ok & ~src;
                // Using the next count gives exactly STRETCH_CYCLES high
                // cycles for a one-cycle pulse (source cycle included).
                MODE_STRETCH: out_d[k] = src | (cnt_d[k] != '0);
                default:      out_d[k] = active_sel_q[k][0];
            endcase
        end
        if (cfg_commit) begin
            cnt_d  = '0;
            prev_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            shadow_sel_q  <= '0;
            shadow_mode_q <= {NUM_OUT{MODE_CONST}};
            active_sel_q  <= '0;
            active_mode_q <= {NUM_OUT{MODE_CONST}};
            cnt_q         <= '0;
            prev_q        <= '0;
            out_q         <= '0;
            pending_q     <= 1'b0;
            err_q         <= 1'b0;
            rd_sel_q      <= '0;
            rd_mode_q     <= MODE_CONST;
        end else begin
            sync_q        <= sync_d;
            shadow_sel_q  <= shadow_sel_d;
            shadow_mode_q <= shadow_mode_d;
            active_sel_q  <= active_sel_d;
            active_mode_q <= active_mode_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            out_q         <= out_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
            rd_sel_q      <= rd_sel_d;
            rd_mode_q     <= rd_mode_d;
        end
    end

    assign output_lines = out_q;
    assign cfg_pending  = pending_q;
    assign cfg_err      = err_q;
    assign rd_sel       = rd_sel_q;
    assign rd_mode      = rd_mode_q;

endmodule

// File: tb/tb_line_matrix_v2.sv
// tb_line_matrix_v2 -- scoreboard bench for line_matrix_v2 with NUM_IN=6,
// NUM_OUT=10, SYNC_STAGES=2, STRETCH_CYCLES=16. Expected values are queued
// with the cycle they are due when stimulus is driven and compared on the
// falling edge of that cycle.
module tb_line_matrix_v2;

    localparam int K_OUT   = 0;
    localparam int K_PEND  = 1;
    localparam int K_ERR   = 2;
    localparam int K_RDSEL = 3;
    localparam int K_RDMOD = 4;

    logic       clk;
    logic       rst;
    logic [5:0] input_lines;
    logic [9:0] output_lines;
    logic       cfg_wr;
    logic [3:0] cfg_addr;
    logic [2:0] cfg_sel;
    logic [1:0] cfg_mode;
    logic       cfg_commit;
    logic       cfg_pending;
    logic       cfg_err;
    logic [3:0] rd_addr;
    logic [2:0] rd_sel;
    logic [1:0] rd_mode;

    typedef struct {
        int          cyc;
        int          kind;
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t  sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [9:0] base;

    line_matrix_v2 #(
        .NUM_IN(6), .NUM_OUT(10), .SYNC_STAGES(2), .STRETCH_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .input_lines(input_lines), .output_lines(output_lines),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode),
        .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_mode(rd_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_OUT:   return 32'(output_lines);
            K_PEND:  return 32'(cfg_pending);
            K_ERR:   return 32'(cfg_err);
            K_RDSEL: return 32'(rd_sel);
            default: return 32'(rd_mode);
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_eq(sb[i].tag, observe(sb[i].kind), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic expect_at(input int dly, input int kind, input string tag, input logic [31:0] val);
        sb.push_back('{cyc + dly, kind, tag, val});
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [2:0] s, input logic [1:0] m);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_sel  = s;
        cfg_mode = m;
        expect_at(1, K_PEND, "pending_set", 1);
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        expect_at(1, K_PEND, "pending_clr", 0);
        step();
        cfg_commit = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        input_lines = 6'h3F;
        cfg_wr      = 1'b0;
        cfg_addr    = '0;
        cfg_sel     = '0;
        cfg_mode    = '0;
        cfg_commit  = 1'b0;
        rd_addr     = '0;

        // Reset with inputs high, then toggle inputs: every output is CONST 0.
        steps(3);
        expect_at(0, K_OUT,   "rst_out", 0);
        expect_at(0, K_PEND,  "rst_pending", 0);
        expect_at(0, K_ERR,   "rst_err", 0);
        expect_at(0, K_RDSEL, "rst_rd_sel", 0);
        expect_at(0, K_RDMOD, "rst_rd_mode", 3);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            input_lines = ~input_lines;
            expect_at(1, K_OUT, "rst_hold_out", 0);
            step();
        end
        input_lines = '0;
        steps(3);

        // PASS: out3 <- in5, rising input visible three edges later.
        cfg_write(4'd3, 3'd5, 2'd0);
        commit();
        steps(2);
        rd_addr = 4'd3;
        expect_at(1, K_RDSEL, "rd_sel_out3", 5);
        expect_at(1, K_RDMOD, "rd_mode_out3", 0);
        input_lines[5] = 1'b1;
        expect_at(1, K_OUT, "pass_lat1", 0);
        expect_at(2, K_OUT, "pass_lat2", 0);
        expect_at(3, K_OUT, "pass_lat3", 10'h008);
        steps(5);
        input_lines[5] = 1'b0;
        expect_at(2, K_OUT, "pass_fall2", 10'h008);
        expect_at(3, K_OUT, "pass_fall3", 0);
        steps(4);

        // INVERT out0 <- in1, CONST out9 = 1.
        cfg_write(4'd0, 3'd1, 2'd1);
        cfg_write(4'd9, 3'd1, 2'd3);
        expect_at(1, K_OUT, "commit_edge_out", 0);
        expect_at(2, K_OUT, "inv_const_out", 10'h201);
        commit();
        steps(2);
        input_lines[1] = 1'b1;
        expect_at(2, K_OUT, "inv_lat2", 10'h201);
        expect_at(3, K_OUT, "inv_lat3", 10'h200);
        steps(4);
        base = 10'h200;

        // STRETCH out2 <- in0: single pulse, then retriggered pulses.
        cfg_write(4'd2, 3'd0, 2'd2);
        commit();
        steps(3);
        for (int d = 0; d < 22; d++) begin
            input_lines[0] = (d == 0);
            expect_at(1, K_OUT, "stretch_single", base | (((d + 1) >= 3 && (d + 1) <= 18) ? 10'h004 : 10'h000));
            step();
        end
        steps(3);
        for (int d = 0; d < 32; d++) begin
            input_lines[0] = (d == 0 || d == 10);
            expect_at(1, K_OUT, "stretch_retrig", base | (((d + 1) >= 3 && (d + 1) <= 28) ? 10'h004 : 10'h000));
            step();
        end
        steps(2);

        // Atomic commit: shadow writes invisible until commit.
        cfg_write(4'd1, 3'd1, 2'd3);
        cfg_write(4'd4, 3'd1, 2'd3);
        expect_at(1, K_OUT,  "shadow_only_out", base);
        expect_at(2, K_OUT,  "shadow_only_out", base);
        expect_at(2, K_PEND, "shadow_pending", 1);
        steps(2);
        cfg_wr     = 1'b1;
        cfg_addr   = 4'd5;
        cfg_sel    = 3'd1;
        cfg_mode   = 2'd3;
        cfg_commit = 1'b1;
        expect_at(1, K_PEND, "wr_commit_pending", 1);
        expect_at(1, K_OUT,  "wr_commit_edge", base);
        expect_at(2, K_OUT,  "wr_commit_out", base | 10'h012);
        expect_at(3, K_OUT,  "wr_commit_out", base | 10'h012);
        step();
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        steps(3);
        expect_at(2, K_OUT, "second_commit_out", base | 10'h032);
        commit();
        steps(3);
        base = base | 10'h032;

        // Write to a nonexistent output.
        cfg_wr   = 1'b1;
        cfg_addr = 4'd12;
        cfg_sel  = 3'd1;
        cfg_mode = 2'd3;
        expect_at(1, K_ERR,  "err_pulse", 1);
        expect_at(1, K_PEND, "err_pending", 0);
        expect_at(2, K_ERR,  "err_clear", 0);
        step();
        cfg_wr = 1'b0;
        steps(2);

        // Out-of-range source select forces 0 in PASS and INVERT.
        cfg_write(4'd6, 3'd7, 2'd0);
        cfg_write(4'd7, 3'd7, 2'd1);
        commit();
        for (int d = 1; d <= 4; d++) expect_at(d, K_OUT, "bad_sel_out", base);
        steps(5);

        // Readback, including an out-of-range index.
        rd_addr = 4'd11;
        expect_at(1, K_RDSEL, "rd_sel_oob", 0);
        expect_at(1, K_RDMOD, "rd_mode_oob", 3);
        step();
        rd_addr = 4'd0;
        expect_at(1, K_RDSEL, "rd_sel_out0", 1);
        expect_at(1, K_RDMOD, "rd_mode_out0", 1);
        step();
        rd_addr = 4'd7;
        expect_at(1, K_RDSEL, "rd_sel_out7", 7);
        expect_at(1, K_RDMOD, "rd_mode_out7", 1);
        step();

        // Reset mid-configuration discards the shadow table.
        cfg_write(4'd8, 3'd1, 2'd3);
        rst = 1'b1;
        expect_at(1, K_OUT,  "midrst_out", 0);
        expect_at(1, K_PEND, "midrst_pending", 0);
        step();
        rst = 1'b0;
        expect_at(2, K_OUT, "midrst_commit_out", 0);
        commit();
        steps(3);

        foreach (sb[i]) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expected %0h at cycle %0d never compared", sb[i].tag, sb[i].val, sb[i].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_matrix_v2.md
Name: line_matrix_v2

Overview:
- Parametrised successor to the GPO line matrix.
- Routes NUM_IN asynchronous RFIC GPO lines to NUM_OUT accessory output lines through a synchronised, registered crossbar.
- Each output has its own source select and mode: pass, invert, pulse-stretch or constant.
- Configuration is written into shadow registers and applied atomically on commit. Sits between the RFIC GPO pins and the accessory connector, driven from EMIO GPIO / an AXI-lite shim.

Parameters:
- NUM_IN, 8, number of input lines (>=2).
- NUM_OUT, 10, number of output lines (>=1).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- STRETCH_CYCLES, 16, hold time in clk cycles for STRETCH mode (>=1).
- SEL_W, clog2(NUM_IN), source select width.
- ADDR_W, clog2(NUM_OUT) (min 1), output index width.

Ports:
- clk  in  1  Block clock.
- rst  in  1  Synchronous reset, active-high.
- input_lines  in  NUM_IN  Asynchronous source lines.
- output_lines  out  NUM_OUT  Registered routed outputs.
- cfg_wr  in  1  Single-cycle shadow write strobe.
- cfg_addr  in  ADDR_W  Output index to write.
- cfg_sel  in  SEL_W  Source index (CONST mode: bit 0 = level).
- cfg_mode  in  2  0=PASS, 1=INVERT, 2=STRETCH, 3=CONST.
- cfg_commit  in  1  Copies all shadow entries to active.
- cfg_pending  out  1  Shadow holds uncommitted writes.
- cfg_err  out  1  Single-cycle pulse: cfg_addr >= NUM_OUT on cfg_wr.
- rd_addr  in  ADDR_W  Readback index (active table).
- rd_sel  out  SEL_W  Active select of rd_addr, registered.
- rd_mode  out  2  Active mode of rd_addr, registered.

Behaviour:
- Reset (rst=1 on a clk edge):
  - Synchroniser flops, stretch counters and output_lines = 0.
  - Shadow and active entries = sel 0, mode CONST (outputs held 0).
  - cfg_pending=0, cfg_err=0, rd_sel=0, rd_mode=CONST.
  - Reset mid-configuration discards uncommitted shadow writes.
- Synchroniser: each input passes through SYNC_STAGES flops; s[i] is the last stage.
- Per-output next value n[k], registered into output_lines[k]:
  - PASS: n = s[sel].
  - INVERT: n = ~s[sel].
  - CONST: n = sel[0].
  - sel >= NUM_IN in PASS, INVERT or STRETCH forces n = 0 (non-power-of-2 NUM_IN).
  - Latency from input edge to output: SYNC_STAGES+1 cycles in PASS and INVERT.
- STRETCH, per output:
  - Tracks the previous s[sel]. A rising edge loads the counter with STRETCH_CYCLES; otherwise the counter decrements while nonzero.
  - n = 1 while counter != 0 or s[sel] == 1.
  - An edge arriving while the counter is nonzero reloads it (retrigger).
  - A single-cycle source pulse yields an output high for exactly STRETCH_CYCLES cycles. A held-high source yields output high for the hold duration plus STRETCH_CYCLES-1 cycles after it falls.
- Configuration:
  - cfg_wr with cfg_addr < NUM_OUT writes shadow[cfg_addr] and sets cfg_pending on the next edge.
  - cfg_wr with cfg_addr >= NUM_OUT is ignored and pulses cfg_err for one cycle.
  - cfg_commit copies every shadow entry to active on the edge, clears cfg_pending and clears all stretch counters and edge-history flops.
  - New routing takes effect on output_lines one cycle after the commit edge.
- Simultaneous cfg_wr and cfg_commit in the same cycle:
  - Commit copies the pre-write shadow.
  - The write lands in shadow, and cfg_pending stays 1.
- cfg_commit with cfg_pending=0 re-copies the identical table. Stretch counters are still cleared.
- Readback: rd_sel and rd_mode present active[rd_addr] one cycle later. rd_addr >= NUM_OUT returns sel 0, mode CONST.
- No output glitch: output_lines change only on clk edges.

Test Plan:
- Reset: drive inputs 0xFF, hold rst 3 cycles -> output_lines=0, cfg_pending=0, rd_mode=3. Keep inputs toggling for 10 cycles -> outputs stay 0.
- PASS latency: write out3 <- in5 PASS, commit, then raise in5 at cycle T -> output_lines[3] rises at T+3 (SYNC_STAGES=2). All other outputs stay 0.
- INVERT and CONST: out0 <- in1 INVERT, out9 CONST sel=1, commit -> out0 = ~in1 after 3 cycles. out9=1 one cycle after the commit edge.
- STRETCH retrigger: out2 <- in0 STRETCH.
  - 1-cycle pulse on in0 -> out2 high exactly 16 cycles.
  - Second pulse 10 cycles after the first -> out2 high 26 cycles total.
- Atomic commit: write out1 and out4 with no commit -> outputs unchanged, cfg_pending=1. Then cfg_wr(out5) in the same cycle as cfg_commit -> out1/out4 update, out5 unchanged, cfg_pending=1. A second commit -> out5 updates, cfg_pending=0.
- Errors: cfg_wr with addr=12 (NUM_OUT=10) -> cfg_err one cycle, cfg_pending unchanged. With NUM_IN=6, PASS sel=7 -> output constant 0. Readback of rd_addr=11 -> sel 0, mode 3.
